// File: rtl/serial_subtractor.sv
// Chunked N-bit subtractor: W bits per cycle from the LSB, done pulses K+1 edges after start is accepted.
// No backpressure: start is honoured only while not busy; results hold until the next completion.
module serial_subtractor #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         borrow,
  output logic         overflow
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   res_q, res_d, d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic           borrow_q, borrow_d, ovf_q, ovf_d;
  logic [W:0]     sum;
  logic [N-1:0]   res_nxt;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    // Operands shift right each cycle, so the active chunk is always the low W bits.
    sum     = {1'b0, a_q[W-1:0]} + {1'b0, ~b_q[W-1:0]} + (W+1)'(carry_q);
    // Result fills from the top; after K chunks the first one has reached bit 0.
    res_nxt = N'({sum[W-1:0], res_q} >> W);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
          carry_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        res_d   = res_nxt;
        carry_d = sum[W];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) begin
          state_d  = DONE;
          d_d      = res_nxt;
          borrow_d = ~sum[W];
          ovf_d    = (a_msb_q != b_msb_q) && (res_nxt[N-1] != a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign D        = d_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at W = 8, 1, 4 and 32 against a scoreboard.
module tb_serial_subtractor;

  typedef struct packed {
    logic [31:0] d;
    logic        br;
    logic        ov;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  start_i = '0;
  logic [3:0]  busy_o, done_o, bor_o, ovf_o;
  logic [31:0] d_o [4];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(32), .W(8))  u_w8  (.clk(clk), .rst_n(rst_n), .start(start_i[0]), .a(a), .b(b),
    .busy(busy_o[0]), .done(done_o[0]), .D(d_o[0]), .borrow(bor_o[0]), .overflow(ovf_o[0]));
  serial_subtractor #(.N(32), .W(1))  u_w1  (.clk(clk), .rst_n(rst_n), .start(start_i[1]), .a(a), .b(b),
    .busy(busy_o[1]), .done(done_o[1]), .D(d_o[1]), .borrow(bor_o[1]), .overflow(ovf_o[1]));
  serial_subtractor #(.N(32), .W(4))  u_w4  (.clk(clk), .rst_n(rst_n), .start(start_i[2]), .a(a), .b(b),
    .busy(busy_o[2]), .done(done_o[2]), .D(d_o[2]), .borrow(bor_o[2]), .overflow(ovf_o[2]));
  serial_subtractor #(.N(32), .W(32)) u_w32 (.clk(clk), .rst_n(rst_n), .start(start_i[3]), .a(a), .b(b),
    .busy(busy_o[3]), .done(done_o[3]), .D(d_o[3]), .borrow(bor_o[3]), .overflow(ovf_o[3]));

  function automatic int k_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 32;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request through the accepting edge and queues the reference result.
  task automatic issue(input int idx, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    a = av;
    b = bv;
    start_i[idx] = 1'b1;
    e.d   = av - bv;
    e.br  = (av < bv);
    e.ov  = (av[31] != bv[31]) && (e.d[31] != av[31]);
    e.lat = 8'(k_of(idx) + 1);
    exp_q.push_back(e);
    tick();
    start_i[idx] = 1'b0;
  endtask

  // cyc0 = edges already elapsed since (and including) the accepting edge.
  task automatic wait_done(input int idx, input int cyc0, input string tag);
    exp_t e;
    int   cyc = cyc0;
    while (!done_o[idx] && cyc < 64) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, 64'(done_o[idx]), 64'd1);
    if (done_o[idx] && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_lat"}, 64'(cyc), 64'(e.lat));
      check({tag, "_D"},   64'(d_o[idx]), 64'(e.d));
      check({tag, "_brw"}, 64'(bor_o[idx]), 64'(e.br));
      check({tag, "_ovf"}, 64'(ovf_o[idx]), 64'(e.ov));
    end
  endtask

  initial begin
    int seen;
    logic [31:0] held;

    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", 64'(busy_o[i]), 64'd0);
      check("rst_done", 64'(done_o[i]), 64'd0);
      check("rst_D",    64'(d_o[i]), 64'd0);
      check("rst_flags", 64'({bor_o[i], ovf_o[i]}), 64'd0);
    end
    rst_n = 1'b1;
    tick();

    // Basic subtraction and inter-chunk borrow
    issue(0, 32'd5, 32'd3);
    check("busy_after_accept", 64'(busy_o[0]), 64'd1);
    wait_done(0, 1, "t1a");
    tick();
    issue(0, 32'h0000_0100, 32'd1);
    wait_done(0, 1, "t1b");

    // Negative result; outputs hold after done drops
    tick();
    issue(0, 32'd3, 32'd5);
    wait_done(0, 1, "t2");
    held = d_o[0];
    tick();
    check("t2_done_drop", 64'(done_o[0]), 64'd0);
    check("t2_D_hold",    64'(d_o[0]), 64'(32'hFFFF_FFFE));
    check("t2_brw_hold",  64'(bor_o[0]), 64'd1);

    // Signed overflow both directions
    issue(0, 32'h8000_0000, 32'd1);
    wait_done(0, 1, "t3a");
    tick();
    issue(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, 1, "t3b");
    tick();

    // Reset mid-run discards the operation
    issue(0, 32'd100, 32'd7);
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_busy", 64'(busy_o[0]), 64'd0);
    check("t5_D",    64'(d_o[0]), 64'd0);
    check("t5_flags", 64'({bor_o[0], ovf_o[0], done_o[0]}), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_o[0] || busy_o[0]) seen++;
      tick();
    end
    check("t5_no_done", 64'(seen), 64'd0);
    issue(0, 32'd9, 32'd9);
    wait_done(0, 1, "t5");
    tick();

    // start during RUN ignored, then back-to-back from DONE
    issue(0, 32'd10, 32'd4);
    tick();
    a = 32'd1;
    b = 32'd1;
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    wait_done(0, 3, "t4a");
    issue(0, 32'd1, 32'd1);
    check("t4_b2b_busy", 64'({busy_o[0], done_o[0]}), 64'b10);
    wait_done(0, 1, "t4b");
    tick();

    // Random sweep across chunk widths including the single-chunk case
    for (int idx = 1; idx < 4; idx++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [31:0] ra, rb;
        ra = $urandom();
        rb = (n % 8 == 0) ? ra ^ 32'(1 << $urandom_range(31)) : $urandom();
        issue(idx, ra, rb);
        wait_done(idx, 1, $sformatf("sweep_k%0d", k_of(idx)));
      end
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle N-bit two's-complement subtractor computing D = a − b over N/W cycles, W bits per cycle from the LSB, with unsigned borrow and signed overflow flags. It is the inverse-operation companion to the single-cycle adder in the arithmetic library. It serves area-constrained datapaths that can tolerate latency, using a start/done handshake so a sequencer can issue back-to-back operations.

## Interface
- N, default 32, operand/result width in bits.
- W, default 8, bits processed per cycle; N must be an integer multiple of W, W ≥ 1; K = N/W chunks.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled on a rising edge only while busy = 0.
- a  input  N  minuend; sampled with an accepted start.
- b  input  N  subtrahend; sampled with an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; the result outputs are valid from this cycle onward.
- D  output  N  difference a − b, modulo 2^N.
- borrow  output  1  1 iff a < b as unsigned numbers, i.e. the inverted final carry of a + ~b + 1.
- overflow  output  1  signed overflow: (a[N-1] ≠ b[N-1]) && (D[N-1] ≠ a[N-1]).

## Operation
- FSM states:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1, done = 0.
  - DONE: busy = 0, done = 1.
- IDLE or DONE with start = 1 → RUN.
  - Latch a and b into internal operand registers.
  - Clear the chunk counter to 0 and set the internal carry to 1, forming a + ~b + 1.
- RUN, on each edge:
  - Chunk i (bits iW+W−1 : iW) = a_chunk + ~b_chunk + carry.
  - The W-bit sum goes into the internal result register.
  - The carry-out becomes the carry-in for chunk i+1.
  - Increment the counter.
- RUN, on the edge that processes chunk K−1 → DONE.
  - Load D from the internal result register (with the final chunk included).
  - Load borrow = ~carry_out.
  - Load overflow per the formula above, using the latched a and b.
- DONE with start = 0 → IDLE. DONE with start = 1 → RUN, with the new operands accepted.
- start during RUN is ignored; the operands and the operation in flight are unaffected.
- D, borrow and overflow change only on entry to DONE and hold until the next completion. Partial results are never visible.
- Arithmetic: all chunk sums are W+1 bits wide; only the top bit propagates as carry; there is no sign extension.

## Timing
- Reset (rst_n = 0 at an edge): state = IDLE, busy = 0, done = 0, D = 0, borrow = 0, overflow = 0, counter = 0.
  - Reset applies from any state, including mid-RUN. The in-flight operation is discarded and no done is produced.
- Accepting start at edge E0:
  - busy = 1 from the cycle after E0.
  - Chunks are processed at edges E1..EK.
  - done = 1 and valid outputs appear in the cycle following EK.
  - Latency is K+1 edges from start acceptance to done; for N = 32, W = 8 that is 5.
- Throughput: with start held high in the DONE cycle, one result every K+1 cycles.
- W = N degenerates to one RUN cycle; the K = 1 boundary must work.
- done is never high for two consecutive cycles unless two operations complete back-to-back. This is impossible for K ≥ 1.

## Test plan
1. N = 32, W = 8, a = 5, b = 3, start pulse → done exactly 5 edges after acceptance, D = 0x00000002, borrow = 0, overflow = 0. Then a = 0x00000100, b = 1 → D = 0x000000FF, exercising inter-chunk borrow.
2. a = 3, b = 5 → D = 0xFFFFFFFE, borrow = 1, overflow = 0; outputs hold after done drops.
3. a = 0x80000000, b = 1 → D = 0x7FFFFFFF, borrow = 0, overflow = 1. Then a = 0x7FFFFFFF, b = 0xFFFFFFFF → D = 0x80000000, borrow = 1, overflow = 1.
4. Start with a = 10, b = 4, then assert start again at RUN cycle 2 with a = 1, b = 1 → the second start is ignored, D = 6. Then hold start in the DONE cycle with a = 1, b = 1 → busy rises next cycle and D = 0 after a further 5 edges.
5. rst_n low for one edge during RUN cycle 2 → all outputs 0, state IDLE, no done pulse. A subsequent operation a = 9, b = 9 gives D = 0, borrow = 0.
6. Parameter sweep W ∈ {1, 4, 32} with N = 32, using 1000 random operand pairs → D, borrow and overflow match a reference model, and latency equals N/W + 1.
